// File: rtl/capt_sched.sv
// capt_sched -- capture descriptor scheduler.
//
// Accepts one packet descriptor at a time. It checks that the byte range is
// legal, hands the range to a capture writer with a one-cycle start pulse and
// waits for the writer's done pulse, with a cycle timeout. It also keeps
// saturating statistics counters.
//
// Ports
//   clk, reset                 rising-edge clock, synchronous active-low reset
//   enable                     permit acceptance of new descriptors
//   desc_valid / desc_ready    descriptor handshake (see below)
//   desc_begin, desc_end       packet byte range [begin, end)
//   ctrl_in                    control word forwarded to the writer
//   pkt_begin, pkt_end, control  range/control presented to the writer
//   wr_ctrl                    one-cycle writer start pulse
//   wr_ctrl_rdy                writer-done pulse (only honoured while waiting)
//   capt_buf_wrap              writer wrapped the capture buffer
//   last_write_addr, last_addr writer's last burst address / copy taken at completion
//   clr_cnt, clr_err           clear statistics / clear sticky timeout error
//   pkt_count, drop_count, wrap_count  saturating statistics
//   busy, timeout_err, irq     not idle, sticky timeout, completion/error pulse
//   dbg_state                  FSM state: 0 IDLE, 1 CHECK, 2 ISSUE, 3 WAIT, 4 DONE, 5 ERR
//
// Handshake: a descriptor transfers on a rising edge where desc_valid and
// desc_ready are both 1. desc_ready depends only on internal state, enable
// and reset, never on desc_valid. The offerer may change the descriptor
// freely while desc_ready is 0.

module capt_sched #(
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter int unsigned MAX_PKT_BYTES  = 2048
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        desc_valid,
  output logic        desc_ready,
  input  logic [31:0] desc_begin,
  input  logic [31:0] desc_end,
  input  logic [31:0] ctrl_in,
  output logic [31:0] pkt_begin,
  output logic [31:0] pkt_end,
  output logic [31:0] control,
  output logic        wr_ctrl,
  input  logic        wr_ctrl_rdy,
  input  logic        capt_buf_wrap,
  input  logic [31:0] last_write_addr,
  output logic [31:0] last_addr,
  input  logic        clr_cnt,
  input  logic        clr_err,
  output logic [31:0] pkt_count,
  output logic [31:0] drop_count,
  output logic [31:0] wrap_count,
  output logic        busy,
  output logic        timeout_err,
  output logic        irq,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } state_t;

  localparam logic [31:0] TIMER_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] MAX_LEN    = 32'(MAX_PKT_BYTES);

  state_t      state_q, state_d;
  logic [31:0] begin_q, end_q, ctrl_q;
  logic [31:0] timer_q;
  logic        wrap_flag_q;
  logic        irq_q;
  logic        terr_q;
  logic [31:0] pkt_count_q, drop_count_q, wrap_count_q;
  logic [31:0] last_addr_q, pkt_begin_q, pkt_end_q, control_q;
  logic        accept;
  logic        len_ok;

  // The length is only meaningful when end > begin, so the order test
  // guards the subtraction.
  assign len_ok = (end_q > begin_q) && ((end_q - begin_q) <= MAX_LEN);
  assign accept = desc_valid && desc_ready;

  always_comb begin
    state_d    = state_q;
    desc_ready = reset && (state_q == IDLE) && enable && !terr_q;
    case (state_q)
      IDLE:    if (accept) state_d = CHECK;
      CHECK:   state_d = len_ok ? ISSUE : IDLE;
      ISSUE:   state_d = WAIT;
      // The writer-done pulse wins over a timeout in the same cycle.
      WAIT:    if (wr_ctrl_rdy) state_d = DONE;
               else if (timer_q == TIMER_LAST) state_d = ERR;
      DONE:    state_d = IDLE;
      ERR:     if (clr_err) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      begin_q      <= '0;
      end_q        <= '0;
      ctrl_q       <= '0;
      timer_q      <= '0;
      wrap_flag_q  <= 1'b0;
      irq_q        <= 1'b0;
      terr_q       <= 1'b0;
      pkt_count_q  <= '0;
      drop_count_q <= '0;
      wrap_count_q <= '0;
      last_addr_q  <= '0;
      pkt_begin_q  <= '0;
      pkt_end_q    <= '0;
      control_q    <= '0;
    end else begin
      state_q <= state_d;

      if (state_q == IDLE && accept) begin
        begin_q <= desc_begin;
        end_q   <= desc_end;
        ctrl_q  <= ctrl_in;
      end

      // Writer-facing values change only when a new packet is issued.
      if (state_q == CHECK && state_d == ISSUE) begin
        pkt_begin_q <= begin_q;
        pkt_end_q   <= end_q;
        control_q   <= ctrl_q;
      end

      if (state_q == ISSUE) begin
        timer_q     <= '0;
        wrap_flag_q <= 1'b0;
      end else if (state_q == WAIT) begin
        timer_q <= timer_q + 32'd1;
        if (capt_buf_wrap) wrap_flag_q <= 1'b1;
      end

      if (state_q == DONE) last_addr_q <= last_write_addr;

      // irq is high for the DONE cycle and for the first ERR cycle.
      irq_q <= (state_q == WAIT) && (state_d == DONE || state_d == ERR);

      if (state_q == WAIT && state_d == ERR) terr_q <= 1'b1;
      else if (clr_err)                      terr_q <= 1'b0;

      // Clearing takes priority over any increment in the same cycle.
      if (clr_cnt) begin
        pkt_count_q  <= '0;
        drop_count_q <= '0;
        wrap_count_q <= '0;
      end else begin
        if (state_q == CHECK && !len_ok && drop_count_q != '1)
          drop_count_q <= drop_count_q + 32'd1;
        if (state_q == DONE && pkt_count_q != '1)
          pkt_count_q <= pkt_count_q + 32'd1;
        if (state_q == DONE && wrap_flag_q && wrap_count_q != '1)
          wrap_count_q <= wrap_count_q + 32'd1;
      end
    end
  end

  assign wr_ctrl     = (state_q == ISSUE);
  assign busy        = (state_q != IDLE);
  assign irq         = irq_q;
  assign timeout_err = terr_q;
  assign pkt_count   = pkt_count_q;
  assign drop_count  = drop_count_q;
  assign wrap_count  = wrap_count_q;
  assign last_addr   = last_addr_q;
  assign pkt_begin   = pkt_begin_q;
  assign pkt_end     = pkt_end_q;
  assign control     = control_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_capt_sched.sv
// Testbench for capt_sched. A behavioural model tracks what the counters and
// writer-facing outputs must be after each descriptor, using the acceptance
// rule (end > begin and end - begin <= MAX_PKT_BYTES) and the writer's
// response chosen by the stimulus. The timeout is set to 8 cycles, so the
// latest ack used anywhere is in the 8th WAIT cycle.

module tb_capt_sched;

  localparam int unsigned TMO    = 8;
  localparam int unsigned MAXB   = 2048;
  localparam logic [2:0]  S_IDLE = 3'd0;
  localparam logic [2:0]  S_CHK  = 3'd1;
  localparam logic [2:0]  S_WAIT = 3'd3;
  localparam logic [2:0]  S_DONE = 3'd4;
  localparam logic [2:0]  S_ERR  = 3'd5;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, enable, desc_valid, desc_ready;
  logic [31:0] desc_begin, desc_end, ctrl_in;
  logic [31:0] pkt_begin, pkt_end, control;
  logic        wr_ctrl, wr_ctrl_rdy, capt_buf_wrap;
  logic [31:0] last_write_addr, last_addr;
  logic        clr_cnt, clr_err;
  logic [31:0] pkt_count, drop_count, wrap_count;
  logic        busy, timeout_err, irq;
  logic [2:0]  dbg_state;

  capt_sched #(.TIMEOUT_CYCLES(TMO), .MAX_PKT_BYTES(MAXB)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .desc_valid(desc_valid), .desc_ready(desc_ready),
    .desc_begin(desc_begin), .desc_end(desc_end), .ctrl_in(ctrl_in),
    .pkt_begin(pkt_begin), .pkt_end(pkt_end), .control(control),
    .wr_ctrl(wr_ctrl), .wr_ctrl_rdy(wr_ctrl_rdy), .capt_buf_wrap(capt_buf_wrap),
    .last_write_addr(last_write_addr), .last_addr(last_addr),
    .clr_cnt(clr_cnt), .clr_err(clr_err),
    .pkt_count(pkt_count), .drop_count(drop_count), .wrap_count(wrap_count),
    .busy(busy), .timeout_err(timeout_err), .irq(irq), .dbg_state(dbg_state)
  );

  // ---------------- pulse monitor ----------------
  int wr_seen  = 0;
  int irq_seen = 0;
  always @(posedge clk) begin
    if (wr_ctrl) wr_seen++;
    if (irq) irq_seen++;
  end

  // ---------------- scoreboard / model ----------------
  logic [31:0] exp_q[$];   // pkt_begin of each accepted descriptor, in order
  int          total = 0;
  int          bad   = 0;
  logic [31:0] m_pkt = 0, m_drop = 0, m_wrap = 0, m_la = 0;
  logic [31:0] m_pb = 0, m_pe = 0, m_ctl = 0;
  int          m_wr = 0, m_irq = 0;
  bit          drop_enable_after_accept = 0;

  function automatic bit legal(input logic [31:0] b, input logic [31:0] e);
    return (e > b) && ((e - b) <= MAXB);
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_stats(input string tag);
    check({tag, ".pkt_count"},  pkt_count,  m_pkt);
    check({tag, ".drop_count"}, drop_count, m_drop);
    check({tag, ".wrap_count"}, wrap_count, m_wrap);
    check({tag, ".last_addr"},  last_addr,  m_la);
    check({tag, ".pkt_begin"},  pkt_begin,  m_pb);
    check({tag, ".pkt_end"},    pkt_end,    m_pe);
    check({tag, ".control"},    control,    m_ctl);
    check({tag, ".wr_pulses"},  32'(wr_seen),  32'(m_wr));
    check({tag, ".irq_pulses"}, 32'(irq_seen), 32'(m_irq));
    check({tag, ".busy"},       {31'd0, busy}, 32'd0);
  endtask

  // ---------------- driver ----------------
  task automatic wait_ready();
    int n = 0;
    while (!desc_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("desc_ready_wait", {31'd0, desc_ready}, 32'd1);
  endtask

  // Offer one descriptor and play the writer. delay = WAIT cycle (1..8) in
  // which the ack arrives; wrap_at = WAIT cycle with a wrap pulse (0 = none).
  task automatic do_pkt(input string tag, input logic [31:0] b, input logic [31:0] e,
                        input logic [31:0] c, input int delay, input int wrap_at,
                        input logic [31:0] la, input bit clr_at_done);
    bit ok;
    ok = legal(b, e);
    wait_ready();
    desc_begin = b; desc_end = e; ctrl_in = c; desc_valid = 1'b1;
    @(negedge clk);
    desc_valid = 1'b0;
    desc_begin = $urandom; desc_end = $urandom; ctrl_in = $urandom;
    if (drop_enable_after_accept) enable = 1'b0;
    check({tag, ".in_check"}, {29'd0, dbg_state}, {29'd0, S_CHK});
    @(negedge clk);
    if (ok) begin
      exp_q.push_back(b);
      m_wr++;
      check({tag, ".wr_ctrl"}, {31'd0, wr_ctrl}, 32'd1);
      check({tag, ".sb_begin"}, pkt_begin, exp_q.pop_front());
      for (int i = 1; i <= delay; i++) begin
        @(negedge clk);
        capt_buf_wrap = (i == wrap_at);
        if (i == delay) begin
          wr_ctrl_rdy = 1'b1;
          last_write_addr = la;
        end
      end
      @(negedge clk);
      wr_ctrl_rdy = 1'b0; capt_buf_wrap = 1'b0;
      check({tag, ".in_done"}, {29'd0, dbg_state}, {29'd0, S_DONE});
      if (clr_at_done) clr_cnt = 1'b1;
      @(negedge clk);
      clr_cnt = 1'b0;
      m_irq++;
      m_pb = b; m_pe = e; m_ctl = c; m_la = la;
      if (clr_at_done) begin
        m_pkt = 0; m_drop = 0; m_wrap = 0;
      end else begin
        m_pkt = sat_inc(m_pkt);
        if (wrap_at >= 1 && wrap_at <= delay) m_wrap = sat_inc(m_wrap);
      end
    end else begin
      check({tag, ".no_wr_ctrl"}, {31'd0, wr_ctrl}, 32'd0);
      m_drop = sat_inc(m_drop);
    end
    @(negedge clk);
    check_stats(tag);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int irq_before;
    reset = 1'b0; enable = 1'b1; desc_valid = 1'b0;
    desc_begin = '0; desc_end = '0; ctrl_in = '0;
    wr_ctrl_rdy = 1'b0; capt_buf_wrap = 1'b0; last_write_addr = '0;
    clr_cnt = 1'b0; clr_err = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.desc_ready", {31'd0, desc_ready}, 32'd0);
    check("rst.timeout_err", {31'd0, timeout_err}, 32'd0);
    check("rst.irq", {31'd0, irq}, 32'd0);
    check("rst.wr_ctrl", {31'd0, wr_ctrl}, 32'd0);
    check("rst.state", {29'd0, dbg_state}, {29'd0, S_IDLE});
    check_stats("rst");
    reset = 1'b1;
    @(negedge clk);
    check("idle.desc_ready", {31'd0, desc_ready}, 32'd1);

    // Basic packet; ack as late as the 8-cycle timeout allows.
    do_pkt("basic", 32'h100, 32'h140, 32'hC0DE, 8, 0, 32'h13C, 0);

    // Empty and oversize ranges are dropped; exact maximum is accepted.
    do_pkt("drop_eq",  32'h200, 32'h200,  32'h1, 3, 0, 32'h0, 0);
    do_pkt("drop_big", 32'h200, 32'h1200, 32'h2, 3, 0, 32'h0, 0);
    do_pkt("max_len",  32'h1000, 32'h1800, 32'h3, 1, 0, 32'h17F0, 0);
    do_pkt("max_len1", 32'h1000, 32'h1801, 32'h4, 1, 0, 32'h0, 0);

    // Timeout: no ack for 8 WAIT cycles.
    wait_ready();
    desc_begin = 32'h300; desc_end = 32'h310; ctrl_in = 32'h5; desc_valid = 1'b1;
    @(negedge clk); desc_valid = 1'b0;
    @(negedge clk); m_wr++; m_pb = 32'h300; m_pe = 32'h310; m_ctl = 32'h5;
    repeat (TMO) @(negedge clk);
    check("tmo.still_wait", {29'd0, dbg_state}, {29'd0, S_WAIT});
    check("tmo.err_not_yet", {31'd0, timeout_err}, 32'd0);
    @(negedge clk);
    check("tmo.state_err", {29'd0, dbg_state}, {29'd0, S_ERR});
    check("tmo.timeout_err", {31'd0, timeout_err}, 32'd1);
    check("tmo.irq", {31'd0, irq}, 32'd1);
    check("tmo.desc_ready", {31'd0, desc_ready}, 32'd0);
    @(negedge clk);
    check("tmo.irq_once", {31'd0, irq}, 32'd0);
    check("tmo.hold_err", {29'd0, dbg_state}, {29'd0, S_ERR});
    m_irq++;
    clr_err = 1'b1;
    @(negedge clk); clr_err = 1'b0;
    check("clr_err.state", {29'd0, dbg_state}, {29'd0, S_IDLE});
    check("clr_err.timeout_err", {31'd0, timeout_err}, 32'd0);
    check("clr_err.desc_ready", {31'd0, desc_ready}, 32'd1);
    check_stats("tmo");

    // Wrap during WAIT counts once; the next packet without wrap does not.
    do_pkt("wrap1",  32'h400, 32'h480, 32'h6, 5, 2, 32'h47C, 0);
    do_pkt("wrap0",  32'h500, 32'h580, 32'h7, 4, 0, 32'h57C, 0);
    do_pkt("wrap_ack", 32'h600, 32'h640, 32'h8, 3, 3, 32'h63C, 0);

    // Enable dropped right after acceptance: packet finishes, no new accept.
    drop_enable_after_accept = 1;
    do_pkt("en_off", 32'h700, 32'h740, 32'h9, 2, 0, 32'h73C, 0);
    drop_enable_after_accept = 0;
    desc_valid = 1'b1; desc_begin = 32'h800; desc_end = 32'h840;
    repeat (3) @(negedge clk);
    check("en_off.ready", {31'd0, desc_ready}, 32'd0);
    check("en_off.idle", {29'd0, dbg_state}, {29'd0, S_IDLE});
    desc_valid = 1'b0; enable = 1'b1;

    // Clear in the DONE cycle wins over the increment.
    do_pkt("clr_done", 32'h900, 32'h940, 32'hA, 2, 1, 32'h93C, 1);

    // Saturation near the top of the packet counter.
    @(negedge clk);
    force dut.pkt_count_q = 32'hFFFF_FFFE;
    #1 release dut.pkt_count_q;
    m_pkt = 32'hFFFF_FFFE;
    for (int k = 0; k < 3; k++)
      do_pkt("sat", 32'hA00 + 32'(k) * 32'h100, 32'hA40 + 32'(k) * 32'h100, 32'(k), 1, 0, 32'(k), 0);

    // Randomized descriptors against the model.
    for (int k = 0; k < 30; k++) begin
      logic [31:0] b, e;
      int d;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: e = b;
        1: e = b - 32'($urandom_range(1, 1000));
        2: e = b + 32'($urandom_range(1, MAXB));
        3: e = b + MAXB;
        4: e = b + MAXB + 1;
        default: e = $urandom;
      endcase
      d = $urandom_range(1, TMO);
      do_pkt("rand", b, e, $urandom, d, $urandom_range(0, d), $urandom, 0);
    end

    // Reset mid-WAIT abandons the packet; a late ack is ignored.
    wait_ready();
    desc_begin = 32'hB00; desc_end = 32'hB40; ctrl_in = 32'hB; desc_valid = 1'b1;
    @(negedge clk); desc_valid = 1'b0;
    @(negedge clk); m_wr++;
    repeat (2) @(negedge clk);
    check("rst_wait.in_wait", {29'd0, dbg_state}, {29'd0, S_WAIT});
    irq_before = irq_seen;
    reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    wr_ctrl_rdy = 1'b1;
    @(negedge clk); wr_ctrl_rdy = 1'b0;
    repeat (2) @(negedge clk);
    m_pkt = 0; m_drop = 0; m_wrap = 0; m_la = 0; m_pb = 0; m_pe = 0; m_ctl = 0;
    check("rst_wait.state", {29'd0, dbg_state}, {29'd0, S_IDLE});
    check("rst_wait.no_irq", 32'(irq_seen), 32'(irq_before));
    check_stats("rst_wait");

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
